// File: rtl/patch_exh_checker.sv
// patch_exh_checker: exhaustively drives all eight {a,b,c} vectors into a patch,
// compares its output with a latched golden truth table and reports the result.
`default_nettype none

module patch_exh_checker #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] golden_tt,
  output logic       vec_a,
  output logic       vec_b,
  output logic       vec_c,
  input  logic       patch_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch_cnt,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] golden_q, golden_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [2:0] ffv_q, ffv_d;
  logic       ffvalid_q, ffvalid_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      settle_q  <= 4'd0;
      golden_q  <= 8'd0;
      mcnt_q    <= 4'd0;
      ffv_q     <= 3'd0;
      ffvalid_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      golden_q  <= golden_d;
      mcnt_q    <= mcnt_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign mismatch = (patch_out != golden_q[idx_q]);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    golden_d  = golden_q;
    mcnt_d    = mcnt_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    done_d    = done_q;
    pass_d    = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          golden_d  = golden_tt;
          idx_d     = 3'd0;
          settle_d  = SETTLE_C;
          mcnt_d    = 4'd0;
          ffv_d     = 3'd0;
          ffvalid_d = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          if (mismatch) begin
            mcnt_d = mcnt_q + 4'd1;
            if (!ffvalid_q) begin
              ffv_d     = idx_q;
              ffvalid_d = 1'b1;
            end
          end
          if (idx_q != 3'd7) begin
            idx_d    = idx_q + 3'd1;
            settle_d = SETTLE_C;
          end else begin
            // The last compare is already folded into mcnt_d here.
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (mcnt_d == 4'd0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {vec_a, vec_b, vec_c} = idx_q;
  assign busy             = (state_q == S_RUN);
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_cnt     = mcnt_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_patch_exh_checker.sv
// Bench for patch_exh_checker: SETTLE=1 and SETTLE=0 instances run side by side
// against a truth-table-difference reference model.
`default_nettype none

module tb_patch_exh_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] golden_tt;
  logic [7:0] ptab;
  int         checks = 0;
  int         failures = 0;

  logic       va1, vb1, vc1, p1, busy1, done1, pass1, ffval1;
  logic [3:0] mcnt1;
  logic [2:0] ffv1;
  logic       va0, vb0, vc0, p0, busy0, done0, pass0, ffval0;
  logic [3:0] mcnt0;
  logic [2:0] ffv0;

  assign p1 = ptab[{va1, vb1, vc1}];
  assign p0 = ptab[{va0, vb0, vc0}];

  patch_exh_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .golden_tt(golden_tt),
    .vec_a(va1), .vec_b(vb1), .vec_c(vc1), .patch_out(p1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(mcnt1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );

  patch_exh_checker #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .golden_tt(golden_tt),
    .vec_a(va0), .vec_b(vb0), .vec_c(vc0), .patch_out(p0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(mcnt0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each differing truth-table bit is one mismatch; lowest such index fails first.
  function automatic void model(input logic [7:0] g, input logic [7:0] p,
                                output int cnt, output logic [2:0] ff, output logic ffv);
    logic [7:0] diff;
    diff = g ^ p;
    cnt = 0;
    ff  = 3'd0;
    ffv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (diff[i]) begin
        cnt++;
        if (!ffv) begin
          ff  = 3'(i);
          ffv = 1'b1;
        end
      end
    end
  endfunction

  task automatic chk_res1(input string tag, input logic [7:0] g, input logic [7:0] p);
    int cnt; logic [2:0] ff; logic ffv;
    model(g, p, cnt, ff, ffv);
    chk({tag, "_cnt1"},  32'(mcnt1),  32'(cnt));
    chk({tag, "_pass1"}, 32'(pass1),  32'(cnt == 0));
    chk({tag, "_ffv1"},  32'(ffv1),   32'(ff));
    chk({tag, "_ffok1"}, 32'(ffval1), 32'(ffv));
  endtask

  task automatic chk_res0(input string tag, input logic [7:0] g, input logic [7:0] p);
    int cnt; logic [2:0] ff; logic ffv;
    model(g, p, cnt, ff, ffv);
    chk({tag, "_cnt0"},  32'(mcnt0),  32'(cnt));
    chk({tag, "_pass0"}, 32'(pass0),  32'(cnt == 0));
    chk({tag, "_ffv0"},  32'(ffv0),   32'(ff));
    chk({tag, "_ffok0"}, 32'(ffval0), 32'(ffv));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_zero1"}, 32'({va1, vb1, vc1, busy1, done1, pass1, mcnt1, ffv1, ffval1}), 32'd0);
    chk({tag, "_zero0"}, 32'({va0, vb0, vc0, busy0, done0, pass0, mcnt0, ffv0, ffval0}), 32'd0);
  endtask

  // One start pulse; golden_tt is inverted mid-run and must not matter.
  task automatic run(input string tag, input logic [7:0] g, input logic [7:0] p);
    @(negedge clk);
    start = 1'b1; golden_tt = g; ptab = p;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_n0"}, 32'({busy1, busy0, done1, done0}), 32'b1100);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 4) golden_tt = ~g;
      chk({tag, "_busy1"}, 32'(busy1), 32'(n < 16));
      chk({tag, "_done1"}, 32'(done1), 32'(n >= 16));
      chk({tag, "_busy0"}, 32'(busy0), 32'(n < 8));
      chk({tag, "_done0"}, 32'(done0), 32'(n >= 8));
      chk({tag, "_vec1"}, 32'({va1, vb1, vc1}), (n < 16) ? 32'(n / 2) : 32'd7);
      chk({tag, "_vec0"}, 32'({va0, vb0, vc0}), (n < 8) ? 32'(n) : 32'd7);
    end
    chk_res1(tag, g, p);
    chk_res0(tag, g, p);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; golden_tt = 8'h00; ptab = 8'hFE;
    #3;
    chk_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("idle");

    run("or_fe", 8'hFE, 8'hFE);
    run("or_ff", 8'hFF, 8'hFE);
    run("or_01", 8'h01, 8'hFE);
    run("stuck101", 8'hFE, 8'hDE);

    // Start held high: no restart during RUN, restart on the first DONE edge.
    @(negedge clk);
    start = 1'b1; golden_tt = 8'hFF; ptab = 8'hFE;
    @(posedge clk); #1;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      if (n == 6) golden_tt = 8'h00;
      chk("hold_busy1", 32'(busy1), 32'(n < 16));
      chk("hold_done1", 32'(done1), 32'(n >= 16));
    end
    chk_res1("hold", 8'hFF, 8'hFE);
    @(posedge clk); #1;
    chk("restart_state", 32'({busy1, done1, pass1, mcnt1}), 32'b1000000);
    start = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      chk("restart_done1", 32'(done1), 32'(n >= 16));
    end
    chk_res1("restart", 8'h00, 8'hFE);

    // Reset pulse mid-run at vector 4.
    @(negedge clk);
    start = 1'b1; golden_tt = 8'h00; ptab = 8'hFE;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_vec1", 32'({va1, vb1, vc1}), 32'd4);
    chk("pre_rst_cnt1", 32'(mcnt1), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("midrun_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero("post_rst");
    run("after_rst", 8'hFE, 8'hFE);

    for (int k = 0; k < 6; k++) begin
      run("rand", 8'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/patch_exh_checker.md
PATCH_EXH_CHECKER -- requirements
Module: patch_exh_checker

Interface
REQ-001 SHALL provide parameter SETTLE, default 1: number of hold cycles added per vector before sampling; legal range 0..15.
REQ-002 SHALL provide port clk, input, 1, single rising-edge clock for all state.
REQ-003 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide port start, input, 1, run request; sampled only in IDLE or DONE.
REQ-005 SHALL provide port golden_tt, input, 8, golden truth table; bit index = {a,b,c}.
REQ-006 SHALL provide ports vec_a, vec_b and vec_c, each an output of width 1, the stimulus driven into the patch inputs a, b and c.
REQ-007 SHALL provide port patch_out, input, 1, patch output (w23) under test.
REQ-008 SHALL provide port busy, output, 1, high while a run is in progress.
REQ-009 SHALL provide port done, output, 1, high from run completion until the next accepted start or reset.
REQ-010 SHALL provide port pass, output, 1, valid while done; 1 means zero mismatches.
REQ-011 SHALL provide port mismatch_cnt, output, 4, number of mismatching vectors in the current or last run (0..8).
REQ-012 SHALL provide port first_fail_vec, output, 3, {a,b,c} of the lowest-index mismatching vector.
REQ-013 SHALL provide port first_fail_valid, output, 1, first_fail_vec holds a captured failure.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE or DONE with start=1 at a rising edge, take the following actions at that edge:
- latch golden_tt;
- set vector index to 0 and load the settle counter with SETTLE;
- clear mismatch_cnt, first_fail_valid, first_fail_vec, done and pass;
- enter RUN.
REQ-016 SHALL ignore start while in RUN; golden_tt changes during RUN SHALL have no effect.
REQ-017 SHALL drive {vec_a,vec_b,vec_c} from the registered vector index, held stable for SETTLE+1 cycles per vector.
REQ-018 SHALL, in RUN with settle counter nonzero, decrement the counter each cycle.
REQ-019 SHALL, in RUN with settle counter 0, sample patch_out at that edge and compare it with latched golden_tt[index].
REQ-020 SHALL, on a compare mismatch, increment mismatch_cnt and, if first_fail_valid=0, capture index into first_fail_vec and set first_fail_valid.
REQ-021 SHALL, after a compare with index<7, increment index and reload the settle counter with SETTLE in the same edge.
REQ-022 SHALL, after a compare with index=7, enter DONE, set done=1, set pass=(final mismatch count==0) and keep index at 7.
REQ-023 SHALL assert done exactly 8*(SETTLE+1) cycles after the start-accepting edge (16 cycles at SETTLE=1).
REQ-024 SHALL hold busy=1 exactly while in RUN; busy and done SHALL never be 1 together.
REQ-025 SHALL, in DONE with start=0, hold all result outputs and vector outputs unchanged.
REQ-026 SHALL include in mismatch_cnt the compare result of the same edge at which DONE is entered.
REQ-027 SHALL be free of combinational paths from patch_out or start to any output.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force the FSM to IDLE.
REQ-029 SHALL, while rst_n=0, drive vec_a, vec_b, vec_c, busy, done, pass, mismatch_cnt, first_fail_vec and first_fail_valid to 0.
REQ-030 SHALL clear the settle counter and latched golden_tt to 0 while rst_n=0.
REQ-031 SHALL abort a run on reset mid-RUN with no partial results retained.
REQ-032 SHALL accept the first start after reset deassertion on the next rising edge where start=1.

Verification
REQ-033 SHALL pass this scenario: patch model = a|b|c, golden_tt=8'hFE, SETTLE=1, start pulse -> busy for 16 cycles, then done=1, pass=1, mismatch_cnt=0, first_fail_valid=0.
REQ-034 SHALL pass this scenario: same patch, golden_tt=8'hFF -> done at 16 cycles, pass=0, mismatch_cnt=1, first_fail_vec=3'b000, first_fail_valid=1.
REQ-035 SHALL pass this scenario: same patch, golden_tt=8'h01 -> mismatch_cnt=8, first_fail_vec=0, pass=0; with SETTLE=0 done comes after 8 cycles.
REQ-036 SHALL pass this scenario: golden_tt=8'hFE, patch output forced 0 only at {a,b,c}=3'b101 -> mismatch_cnt=1, first_fail_vec=3'b101.
REQ-037 SHALL pass this scenario:
- start held high throughout a run -> no restart until DONE;
- the next edge in DONE restarts the run, clearing done, pass and mismatch_cnt;
- golden_tt toggled mid-run -> no effect on results.
REQ-038 SHALL pass this scenario: rst_n pulsed low at vector 4 -> all outputs 0 immediately, state IDLE; a new start then gives a clean full 16-cycle run.
